// File: rtl/ps2_key_event_fifo.sv
// PS/2 keyboard front end: pin synchronisers, 11-bit frame receiver with
// start/parity/stop/timeout checking, E0/F0 prefix decoder, typematic repeat
// filter, key press counter and a first-word fall-through event FIFO.
module ps2_key_event_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000,
    parameter bit REPEAT_EN   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          key_down,
    output logic [7:0]                    last_code,
    output logic [CNT_W-1:0]              key_count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    TO_ONE   = TW'(1);
    localparam logic [AW:0]      LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]      LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    // ------------------------------------------------------------------
    // Pin synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Bring both pins into the clk domain; idle level of the bus is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver: bit_cnt 0 = waiting for start, 1..8 data,
    // 9 parity, 10 stop. vld_p0/err_p0 are one-cycle strobes.
    // ------------------------------------------------------------------
    logic [3:0]    bit_cnt;
    logic [TW-1:0] timer;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [7:0]    byte_p0;
    logic          vld_p0;
    logic          err_p0;

    // Bit counter, inter-edge timeout and frame check strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= 4'd0;
            timer   <= '0;
            vld_p0  <= 1'b0;
            err_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            err_p0 <= 1'b0;
            if (fall) begin
                timer <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!data_s) begin
                        bit_cnt <= 4'd1;
                    end else begin
                        err_p0  <= 1'b1;
                    end
                end else if (bit_cnt < 4'd10) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end else begin
                    bit_cnt <= 4'd0;
                    // Stop must be high and data+parity must hold an odd count of ones.
                    if (data_s && (^{par_bit, shreg})) begin
                        vld_p0 <= 1'b1;
                    end else begin
                        err_p0 <= 1'b1;
                    end
                end
            end else if (bit_cnt != 4'd0) begin
                if (timer == TO_LAST) begin
                    bit_cnt <= 4'd0;
                    timer   <= '0;
                    err_p0  <= 1'b1;
                end else begin
                    timer   <= timer + TO_ONE;
                end
            end else begin
                timer <= '0;
            end
        end
    end

    // Data capture: shift in LSB first, latch parity, hand the byte to p0 on the stop bit.
    always_ff @(posedge clk) begin
        if (fall) begin
            if ((bit_cnt >= 4'd1) && (bit_cnt <= 4'd8)) begin
                shreg <= {data_s, shreg[7:1]};
            end
            if (bit_cnt == 4'd9) begin
                par_bit <= data_s;
            end
            if (bit_cnt == 4'd10) begin
                byte_p0 <= shreg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder (byte_p0/vld_p0 -> one event per key action)
    // ------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ev_fire;
    logic       ev_ext_d;
    logic       ev_brk_d;

    // Next-state and event generation from the received byte.
    always_comb begin
        state_nxt = state;
        ev_fire   = 1'b0;
        ev_ext_d  = 1'b0;
        ev_brk_d  = 1'b0;
        if (err_p0) begin
            state_nxt = ST_IDLE;
        end else if (vld_p0) begin
            case (state)
                ST_IDLE: begin
                    if (byte_p0 == CODE_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (byte_p0 == CODE_BRK) begin
                        state_nxt = ST_BRK;
                    end else begin
                        ev_fire   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (byte_p0 == CODE_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else begin
                        ev_fire   = 1'b1;
                        ev_ext_d  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_nxt = ST_IDLE;
                    if (byte_p0 != CODE_EXT) begin
                        ev_fire  = 1'b1;
                        ev_brk_d = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    if (byte_p0 != CODE_EXT) begin
                        ev_fire  = 1'b1;
                        ev_ext_d = 1'b1;
                        ev_brk_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Held-key tracking, repeat filter and press counter
    // ------------------------------------------------------------------
    logic held_ext;
    logic held_match;
    logic is_repeat;
    logic push;

    assign held_match = ({held_ext, last_code} == {ev_ext_d, byte_p0});
    assign is_repeat  = key_down & held_match;
    assign push       = ev_fire & (ev_brk_d | ~is_repeat | REPEAT_EN);

    // Update counters and the held key on every decoded event, pushed or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_count <= '0;
            key_down  <= 1'b0;
            last_code <= 8'd0;
            held_ext  <= 1'b0;
        end else if (ev_fire) begin
            if (!ev_brk_d) begin
                if (!is_repeat) begin
                    key_count <= key_count + CNT_ONE;
                    last_code <= byte_p0;
                    held_ext  <= ev_ext_d;
                    key_down  <= 1'b1;
                end
            end else if (held_match) begin
                key_down <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO, first-word fall-through
    // ------------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [9:0]    head;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign full    = (fifo_level == LVL_FULL);
    assign do_pop  = rd_en & ev_valid;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign head     = mem[rd_ptr];
    assign ev_valid = (fifo_level != '0);
    assign ev_code  = ev_valid ? head[7:0] : 8'd0;
    assign ev_break = ev_valid & head[8];
    assign ev_ext   = ev_valid & head[9];

    // Pointers and occupancy; a simultaneous push and pop leaves the level alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                fifo_level <= fifo_level + LVL_ONE;
            end else if (do_pop && !do_push) begin
                fifo_level <= fifo_level - LVL_ONE;
            end
        end
    end

    // Event storage, packed as {ext, break, code}.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {ev_ext_d, ev_brk_d, byte_p0};
        end
    end

    // Sticky error flags; a new set beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= drop   | (overflow  & ~clr_err);
            frame_err <= err_p0 | (frame_err & ~clr_err);
        end
    end

endmodule
